sraa_encoder_ctrl: RTL and testbench
====================================

SRAA_ENCODER_CTRL -- requirements
Module: sraa_encoder_ctrl

Interface
REQ-001 Parameter CIRC_SIZE, default 16, SHALL set the circulant size (bits accumulated per generator block).
REQ-002 Parameter NUM_BLK, default 4, SHALL set the number of generator circulant blocks per codeword.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 clear  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin encoding one codeword; sampled only in IDLE.
REQ-006 info_bit  input  1  serial information bit.
REQ-007 info_valid  input  1  info_bit valid this cycle.
REQ-008 info_ready  output  1  controller accepts info_bit this cycle.
REQ-009 rom_addr  output  max(1,clog2(NUM_BLK))  generator first-row ROM address (current block).
REQ-010 load_shift_reg  output  1  load ROM row into the cyclic generator register.
REQ-011 gi_shift  output  1  cyclic-shift enable for the generator register.
REQ-012 load_reg  output  1  accumulator register load enable.
REQ-013 sraa_clear  output  1  synchronous clear of the accumulator, active-high.
REQ-014 info_bit_out  output  1  gated info bit to the SRAA datapath.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse; accumulator holds final parity.

Function
REQ-017 FSM states SHALL be IDLE, CLR, LOAD, ACC and DONE, with all outputs decoded from registered state and counters (Moore, except the handshake-qualified outputs in REQ-021).
REQ-018 IDLE: all outputs 0; start=1 -> CLR; start=0 -> stay.
REQ-019 CLR (1 cycle): sraa_clear=1, blk_cnt<=0, bit_cnt<=0 -> LOAD.
REQ-020 LOAD (1 cycle): rom_addr=blk_cnt, load_shift_reg=1, gi_shift=0, load_reg=0 -> ACC.
REQ-021 ACC: info_ready=1; accept = info_valid & info_ready; on accept, load_reg=1, gi_shift=1 and bit_cnt increments; without accept, load_reg=0 and gi_shift=0 (stall, datapath frozen).
REQ-022 ACC, accept with bit_cnt==CIRC_SIZE-1: bit_cnt<=0; if blk_cnt==NUM_BLK-1 -> DONE, else blk_cnt<=blk_cnt+1 -> LOAD.
REQ-023 DONE (1 cycle): done=1, busy=1 -> IDLE; accumulator is not cleared until the next CLR.
REQ-024 info_bit_out SHALL equal info_bit & accept, and 0 otherwise.
REQ-025 rom_addr SHALL hold blk_cnt in LOAD and ACC, and 0 in all other states.
REQ-026 bit_cnt width SHALL be clog2(CIRC_SIZE)+1; counters SHALL never exceed CIRC_SIZE-1 and NUM_BLK-1 (no wrap beyond terminal value).
REQ-027 With info_valid held high, done SHALL assert exactly 2+NUM_BLK*(CIRC_SIZE+1) cycles after the cycle start is sampled (70 cycles at defaults).
REQ-028 start asserted in any state other than IDLE SHALL be ignored, including in the DONE cycle.
REQ-029 info_valid outside ACC SHALL be ignored: info_ready=0, with no effect on state or counters.
REQ-030 Stalls of any length in ACC SHALL NOT change bit_cnt, blk_cnt or state.

Reset
REQ-031 clear=0 SHALL immediately force IDLE, blk_cnt=0, bit_cnt=0 and all outputs 0, regardless of state.
REQ-032 Reset deassertion SHALL leave the block in IDLE, requiring a new start; a codeword interrupted mid-operation is discarded.

Verification
REQ-033 Reset, then start=1 for 1 cycle with info_valid=1 continuously -> CLR, LOAD, then 16 ACC accepts; rom_addr steps 0,1,2,3; 4 load_shift_reg pulses; done at start+70; busy low afterwards.
REQ-034 Random info_valid (~50% duty) -> exactly 64 load_reg/gi_shift pulses, each coincident with accept; counters frozen during stalls; done exactly once.
REQ-035 info_bit pattern 1,0,1,1... against a golden model of the generator register and accumulator -> final 16-bit accumulator matches the reference parity for all 4 blocks.
REQ-036 clear=0 asserted at bit 7 of block 2 -> all outputs 0 in the same cycle; after release, state is IDLE; a new start re-encodes from block 0 correctly.
REQ-037 start pulsed during ACC and in the DONE cycle -> ignored; a start one cycle after DONE launches a new codeword with sraa_clear=1.
REQ-038 Parameter sweep CIRC_SIZE=8, NUM_BLK=1 -> done at start+11; rom_addr width 1, held at 0.

Source files
------------

// File: rtl/sraa_encoder_ctrl.sv
// ---------------------------------------------------------------------------
// sraa_encoder_ctrl
//
// Control FSM for a shift-register-adder-accumulator (SRAA) quasi-cyclic
// encoder. For each of NUM_BLK generator circulant blocks it loads the first
// row of the block from ROM into a cyclic generator register. It then accepts
// CIRC_SIZE serial information bits. Each accepted bit XORs the current
// generator row into the accumulator (when the bit is 1) and rotates the
// generator register by one position. After the last bit of the last block,
// the accumulator holds the parity and done pulses for one cycle.
//
// Ports
//   clk            : clock, rising edge
//   clear          : asynchronous active-low reset
//   start          : begin one codeword (only looked at in IDLE)
//   info_bit       : serial information bit
//   info_valid     : info_bit is valid this cycle
//   info_ready     : controller accepts info_bit this cycle (ACC state)
//   rom_addr       : generator ROM address (current block in LOAD/ACC, else 0)
//   load_shift_reg : load the ROM row into the generator register
//   gi_shift       : rotate the generator register
//   load_reg       : accumulator load enable
//   sraa_clear     : synchronous clear of the accumulator
//   info_bit_out   : info bit qualified by the handshake
//   busy           : high in every state except IDLE
//   done           : one-cycle pulse, accumulator holds the final parity
//   dbg_state      : current FSM state encoding, for observation only
//
// Handshake: a bit transfers on a cycle where info_valid && info_ready are
// both high. info_ready depends only on registered state, never on
// info_valid. A producer may hold info_valid high for any number of cycles.
// Cycles without a transfer freeze the datapath and all counters.
// ---------------------------------------------------------------------------
module sraa_encoder_ctrl #(
  parameter int CIRC_SIZE = 16,
  parameter int NUM_BLK   = 4,
  localparam int BLK_W    = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1,
  localparam int BIT_W    = $clog2(CIRC_SIZE) + 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             info_bit,
  input  logic             info_valid,
  output logic             info_ready,
  output logic [BLK_W-1:0] rom_addr,
  output logic             load_shift_reg,
  output logic             gi_shift,
  output logic             load_reg,
  output logic             sraa_clear,
  output logic             info_bit_out,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_LOAD = 3'd2,
    S_ACC  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CIRC_SIZE - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(NUM_BLK - 1);

  state_e             state_q, state_d;
  logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               accept;

  assign accept = (state_q == S_ACC) && info_valid;

  // Next-state and counter update.
  always_comb begin
    state_d   = state_q;
    blk_cnt_d = blk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLR;
      end
      S_CLR: begin
        blk_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_ACC;
      end
      S_ACC: begin
        if (accept) begin
          if (bit_cnt_q == BIT_LAST) begin
            // The last bit of the block has arrived. Either move on to the
            // next block's ROM row or finish the codeword. Neither counter
            // goes past its terminal value.
            bit_cnt_d = '0;
            if (blk_cnt_q == BLK_LAST) begin
              state_d = S_DONE;
            end else begin
              blk_cnt_d = blk_cnt_q + BLK_W'(1);
              state_d   = S_LOAD;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      blk_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      blk_cnt_q <= blk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Outputs are decoded from registered state. load_reg, gi_shift and
  // info_bit_out are also qualified by the handshake. Because the reset is
  // asynchronous, all outputs fall to 0 as soon as clear goes low.
  assign info_ready     = (state_q == S_ACC);
  assign load_reg       = accept;
  assign gi_shift       = accept;
  assign info_bit_out   = info_bit && accept;
  assign load_shift_reg = (state_q == S_LOAD);
  assign sraa_clear     = (state_q == S_CLR);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign rom_addr       = ((state_q == S_LOAD) || (state_q == S_ACC)) ? blk_cnt_q : '0;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_sraa_encoder_ctrl.sv
module tb_sraa_encoder_ctrl;

  localparam int CS = 16;
  localparam int NB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clear;
  logic start, info_bit, info_valid;
  logic info_ready, load_shift_reg, gi_shift, load_reg, sraa_clear, info_bit_out, busy, done;
  logic [1:0] rom_addr;
  logic [2:0] dbg_state;

  logic start_s, info_bit_s, info_valid_s;
  logic info_ready_s, load_shift_reg_s, gi_shift_s, load_reg_s, sraa_clear_s, info_bit_out_s, busy_s, done_s;
  logic [0:0] rom_addr_s;
  logic [2:0] dbg_state_s;

  sraa_encoder_ctrl #(.CIRC_SIZE(CS), .NUM_BLK(NB)) dut (
    .clk(clk), .clear(clear), .start(start), .info_bit(info_bit), .info_valid(info_valid),
    .info_ready(info_ready), .rom_addr(rom_addr), .load_shift_reg(load_shift_reg),
    .gi_shift(gi_shift), .load_reg(load_reg), .sraa_clear(sraa_clear),
    .info_bit_out(info_bit_out), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  sraa_encoder_ctrl #(.CIRC_SIZE(8), .NUM_BLK(1)) dut_s (
    .clk(clk), .clear(clear), .start(start_s), .info_bit(info_bit_s), .info_valid(info_valid_s),
    .info_ready(info_ready_s), .rom_addr(rom_addr_s), .load_shift_reg(load_shift_reg_s),
    .gi_shift(gi_shift_s), .load_reg(load_reg_s), .sraa_clear(sraa_clear_s),
    .info_bit_out(info_bit_out_s), .busy(busy_s), .done(done_s), .dbg_state(dbg_state_s)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] rom [NB];

  function automatic logic [15:0] rotl_n(input logic [15:0] g, input int n);
    logic [15:0] r;
    r = g;
    for (int i = 0; i < n; i++) r = {r[14:0], r[15]};
    return r;
  endfunction

  function automatic logic [9:0] outs();
    return {busy, sraa_clear, load_shift_reg, info_ready, load_reg, gi_shift,
            info_bit_out, done, rom_addr};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      info_valid = 1'($urandom_range(0, 1));
      info_bit = 1'($urandom_range(0, 1));
      @(negedge clk);
      vectors++;
      if (outs() !== 10'b0) begin
        miscompares++;
        $display("FAIL %s got %b expected %b", tag, outs(), 10'b0);
      end
    end
  endtask

  // One codeword. The reference is a timeline driven by the accepted-bit
  // count: CLR, LOAD, then CS accepts per block, with a LOAD between blocks
  // and DONE after the last one. A separate SRAA datapath model is driven by
  // the DUT strobes. Its final accumulator is checked against a parity
  // computed directly from the accepted bits and the ROM rows.
  task automatic run_word(input int pct, input bit rnd_bits, input bit poke_start, input string tag);
    int ph, acc_n, stalls, done_k, n_load_reg, n_lsr, n_done;
    bit finished, v, b, acpt;
    logic [15:0] gen, accum, expp;
    logic [9:0] exp_o;
    logic exp_q[$];

    @(posedge clk); #1;
    start = 1'b1;
    info_valid = 1'($urandom_range(0, 1));
    info_bit = 1'($urandom_range(0, 1));
    @(negedge clk);
    vectors++;
    if (outs() !== 10'b0) begin
      miscompares++;
      $display("FAIL %s_idle_start got %b expected %b", tag, outs(), 10'b0);
    end

    ph = 0; acc_n = 0; stalls = 0; done_k = -1; finished = 0;
    n_load_reg = 0; n_lsr = 0; n_done = 0;
    gen = '0; accum = '0;
    for (int k = 1; k <= 2000 && !finished; k++) begin
      @(posedge clk); #1;
      start = poke_start ? ((ph == 3) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
      v = ($urandom_range(0, 99) < pct);
      b = rnd_bits ? 1'($urandom_range(0, 1)) : ((acc_n % 4) != 1);
      info_valid = v;
      info_bit = b;
      @(negedge clk);
      acpt = (ph == 2) && v;
      exp_o = {1'b1, ph == 0, ph == 1, ph == 2, acpt, acpt, acpt && b, ph == 3,
               ((ph == 1) || (ph == 2)) ? 2'(acc_n / CS) : 2'b00};
      vectors++;
      if (outs() !== exp_o) begin
        miscompares++;
        $display("FAIL %s_outputs cycle %0d got %b expected %b", tag, k, outs(), exp_o);
      end
      if (load_reg) n_load_reg++;
      if (load_shift_reg) n_lsr++;
      if (done) begin n_done++; if (done_k < 0) done_k = k; end
      // datapath model clocked by the DUT strobes
      if (sraa_clear) accum = '0;
      if (load_reg && info_bit_out) accum = accum ^ gen;
      if (load_shift_reg) gen = rom[rom_addr];
      else if (gi_shift) gen = rotl_n(gen, 1);
      // timeline
      case (ph)
        0: ph = 1;
        1: ph = 2;
        2: begin
          if (acpt) begin
            exp_q.push_back(b);
            acc_n++;
            if (acc_n % CS == 0) ph = (acc_n == NB * CS) ? 3 : 1;
          end else begin
            stalls++;
          end
        end
        default: finished = 1;
      endcase
    end

    vectors++;
    if (!finished) begin
      miscompares++;
      $display("FAIL %s_timeout got no completion expected done within 2000 cycles", tag);
    end
    vectors++;
    if (done_k != 2 + NB * (CS + 1) + stalls) begin
      miscompares++;
      $display("FAIL %s_done_latency got %0d expected %0d", tag, done_k, 2 + NB * (CS + 1) + stalls);
    end
    vectors++;
    if (n_load_reg != NB * CS || n_lsr != NB || n_done != 1) begin
      miscompares++;
      $display("FAIL %s_pulse_counts got load_reg=%0d lsr=%0d done=%0d expected %0d %0d 1",
               tag, n_load_reg, n_lsr, n_done, NB * CS, NB);
    end
    expp = '0;
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i]) expp = expp ^ rotl_n(rom[i / CS], i % CS);
    vectors++;
    if (accum !== expp) begin
      miscompares++;
      $display("FAIL %s_parity got %h expected %h", tag, accum, expp);
    end
    start = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear = 1'b0; start = 1'b0; info_valid = 1'b1; info_bit = 1'b1;
    start_s = 1'b0; info_valid_s = 1'b0; info_bit_s = 1'b0;
    #23;
    vectors++;
    if (outs() !== 10'b0 || busy_s !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b/%b expected %b/0", outs(), busy_s, 10'b0);
    end
    @(negedge clk); clear = 1'b1;
    check_idle(4, "idle_ignores_valid");
  endtask

  task automatic test_full_run();
    run_word(100, 1'b0, 1'b0, "full_run");
    check_idle(2, "full_run_after");
  endtask

  task automatic test_random_stall();
    run_word(50, 1'b1, 1'b0, "stall");
    check_idle(1, "stall_after");
  endtask

  task automatic test_back_to_back();
    run_word(70, 1'b1, 1'b1, "ignored_start");
    run_word(100, 1'b1, 1'b0, "back_to_back");
    check_idle(1, "b2b_after");
  endtask

  task automatic test_abort();
    @(posedge clk); #1;
    start = 1'b1; info_valid = 1'b1; info_bit = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (43) @(posedge clk);
    #2;
    vectors++;
    if (rom_addr !== 2'd2 || load_reg !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_position got addr=%0d load_reg=%b expected 2 1", rom_addr, load_reg);
    end
    clear = 1'b0;
    #1;
    vectors++;
    if (outs() !== 10'b0) begin
      miscompares++;
      $display("FAIL abort_outputs got %b expected %b", outs(), 10'b0);
    end
    @(negedge clk); #2;
    clear = 1'b1;
    check_idle(3, "abort_idle");
    run_word(100, 1'b1, 1'b0, "after_abort");
    check_idle(1, "after_abort_idle");
  endtask

  task automatic test_sweep();
    int done_k;
    done_k = -1;
    @(posedge clk); #1;
    start_s = 1'b1; info_valid_s = 1'b1; info_bit_s = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 200 && done_k < 0; k++) begin
      @(posedge clk); #1;
      start_s = 1'b0;
      info_bit_s = 1'($urandom_range(0, 1));
      @(negedge clk);
      vectors++;
      if (rom_addr_s !== 1'b0 || busy_s !== 1'b1) begin
        miscompares++;
        $display("FAIL sweep_cycle %0d got addr=%b busy=%b expected 0 1", k, rom_addr_s, busy_s);
      end
      if (done_s) done_k = k;
    end
    vectors++;
    if (done_k != 11) begin
      miscompares++;
      $display("FAIL sweep_done_latency got %0d expected 11", done_k);
    end
    @(posedge clk); #1;
    info_valid_s = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy_s !== 1'b0) begin
      miscompares++;
      $display("FAIL sweep_after_busy got %b expected 0", busy_s);
    end
  endtask

  initial begin
    for (int i = 0; i < NB; i++) rom[i] = 16'($urandom());
    test_reset();
    test_full_run();
    test_random_stall();
    test_back_to_back();
    test_abort();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
